// File: rtl/sc_spi_tgt.sv
// SPI target engine: oversamples SCLK/CSB/MOSI in the system clock domain, assembles received
// words and serialises a one-entry TX holding register onto MISO. Supports SPI modes 0-3.
module sc_spi_tgt #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_sysclk,
    input  logic        i_sysrst,
    input  logic        i_cpol,
    input  logic        i_cpha,
    input  logic        i_border,
    input  logic [4:0]  i_dwidth,
    input  logic [31:0] i_txdata,
    input  logic        i_txvalid,
    output logic        o_txready,
    output logic        o_txundr,
    output logic [31:0] o_rxdata,
    output logic        o_rxvalid,
    output logic        o_frameact,
    output logic        o_frameend,
    input  logic        i_sclk,
    input  logic        i_csb,
    input  logic        i_mosi,
    output logic        o_miso,
    output logic        o_misooe
);

    // state | meaning
    // IDLE  | CSB high, waiting for a frame start
    // START | one cycle: load TX shift register, latch nothing further
    // SHIFT | frame active, bits move on sample/shift edges
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_SHIFT} state_t;

    state_t r_state;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_csb_sync, r_mosi_sync;
    logic        r_sclk_prev, r_csb_prev;
    logic        r_cpol, r_cpha, r_border;
    logic [4:0]  r_dwidth, r_bc;
    logic [31:0] r_hold, r_tx_sr, r_rx_sr, r_rxdata;
    logic        r_full, r_miso, r_txundr, r_rxvalid, r_frameact, r_frameend, r_word_done;

    logic        w_sclk, w_csb, w_mosi;
    logic        w_sclk_rise, w_sclk_fall, w_csb_rise, w_csb_fall;
    logic        w_lead, w_trail, w_sample, w_shift, w_word_end, w_reload, w_accept;
    logic [31:0] w_reload_word, w_rx_next;

    function automatic logic f_head(input logic [31:0] w, input logic bo, input logic [4:0] dw);
        return bo ? w[0] : w[dw];
    endfunction

    function automatic logic [31:0] f_shift(input logic [31:0] w, input logic bo);
        return bo ? (w >> 1) : (w << 1);
    endfunction

    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            r_sclk_sync <= {SYNC_STAGES{i_cpol}};
            r_csb_sync  <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= i_cpol;
            r_csb_prev  <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_csb_sync  <= {r_csb_sync[SYNC_STAGES-2:0], i_csb};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sclk_prev <= w_sclk;
            r_csb_prev  <= w_csb;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_csb       = r_csb_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk & r_sclk_prev;
    assign w_csb_rise  = w_csb & ~r_csb_prev;
    assign w_csb_fall  = ~w_csb & r_csb_prev;

    assign w_lead   = r_cpol ? w_sclk_fall : w_sclk_rise;
    assign w_trail  = r_cpol ? w_sclk_rise : w_sclk_fall;
    assign w_sample = r_cpha ? w_trail : w_lead;
    assign w_shift  = r_cpha ? w_lead : w_trail;

    assign w_word_end    = (r_state == ST_SHIFT) && w_sample && (r_bc == r_dwidth);
    assign w_reload      = ~w_csb_rise && ((r_state == ST_START) || w_word_end);
    assign w_accept      = i_txvalid & ~r_full;
    assign w_reload_word = r_full ? r_hold : 32'h0;
    // LSB-first words enter at the top of the active field and walk down to bit 0
    assign w_rx_next     = r_border ? ((r_rx_sr >> 1) | ({31'h0, w_mosi} << r_dwidth))
                                    : {r_rx_sr[30:0], w_mosi};

    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            r_state     <= ST_IDLE;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_border    <= 1'b0;
            r_dwidth    <= '0;
            r_bc        <= '0;
            r_hold      <= '0;
            r_full      <= 1'b0;
            r_tx_sr     <= '0;
            r_rx_sr     <= '0;
            r_rxdata    <= '0;
            r_miso      <= 1'b0;
            r_txundr    <= 1'b0;
            r_rxvalid   <= 1'b0;
            r_frameact  <= 1'b0;
            r_frameend  <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            r_txundr    <= 1'b0;
            r_rxvalid   <= 1'b0;
            r_frameend  <= 1'b0;
            r_word_done <= 1'b0;
            r_frameact  <= ~w_csb;

            // a reload and an accept in the same cycle: reload sees the old (empty) holding state
            if (w_accept) begin
                r_hold <= i_txdata;
                r_full <= 1'b1;
            end else if (w_reload) begin
                r_full <= 1'b0;
            end
            if (w_reload && !r_full)
                r_txundr <= 1'b1;

            if (r_word_done) begin
                r_rxdata  <= r_rx_sr;
                r_rxvalid <= 1'b1;
                r_rx_sr   <= '0;
            end

            if (w_csb_rise) begin
                r_state    <= ST_IDLE;
                r_frameend <= 1'b1;
                r_miso     <= 1'b0;
                r_bc       <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_csb_fall) begin
                            r_cpol   <= i_cpol;
                            r_cpha   <= i_cpha;
                            r_border <= i_border;
                            r_dwidth <= i_dwidth;
                            r_state  <= ST_START;
                        end
                    end
                    ST_START: begin
                        r_bc    <= '0;
                        r_rx_sr <= '0;
                        if (!r_cpha) begin
                            r_miso  <= f_head(w_reload_word, r_border, r_dwidth);
                            r_tx_sr <= f_shift(w_reload_word, r_border);
                        end else begin
                            r_tx_sr <= w_reload_word;
                        end
                        r_state <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (w_shift) begin
                            r_miso  <= f_head(r_tx_sr, r_border, r_dwidth);
                            r_tx_sr <= f_shift(r_tx_sr, r_border);
                        end else if (w_sample) begin
                            r_rx_sr <= w_rx_next;
                            if (r_bc == r_dwidth) begin
                                r_bc        <= '0;
                                r_word_done <= 1'b1;
                                r_tx_sr     <= w_reload_word;
                            end else begin
                                r_bc <= r_bc + 5'd1;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_txready  = ~r_full;
    assign o_txundr   = r_txundr;
    assign o_rxdata   = r_rxdata;
    assign o_rxvalid  = r_rxvalid;
    assign o_frameact = r_frameact;
    assign o_frameend = r_frameend;
    assign o_miso     = r_miso;
    assign o_misooe   = r_frameact;

endmodule

// File: tb/tb_sc_spi_tgt.sv
// Directed + randomised bench for sc_spi_tgt: a behavioural SPI master drives the pins and the
// expected words come from the bit-order rules applied to the words the bench chose.
module tb_sc_spi_tgt;
    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        rst, cpol, cpha, border, txvalid, sclk, csb, mosi;
    logic [4:0]  dwidth;
    logic [31:0] txdata;
    logic        txready, txundr, rxvalid, frameact, frameend, miso, misooe;
    logic [31:0] rxdata;

    always #5 clk = ~clk;

    sc_spi_tgt #(.SYNC_STAGES(SS)) dut (
        .i_sysclk(clk), .i_sysrst(rst), .i_cpol(cpol), .i_cpha(cpha), .i_border(border),
        .i_dwidth(dwidth), .i_txdata(txdata), .i_txvalid(txvalid), .o_txready(txready),
        .o_txundr(txundr), .o_rxdata(rxdata), .o_rxvalid(rxvalid), .o_frameact(frameact),
        .o_frameend(frameend), .i_sclk(sclk), .i_csb(csb), .i_mosi(mosi), .o_miso(miso),
        .o_misooe(misooe)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int undr_cnt = 0;
    int fend_cnt = 0;
    int last_sample_cyc = 0;
    logic [31:0] rx_log[$];
    int          rx_cyc[$];
    logic [31:0] miso_words[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rxvalid) begin
            rx_log.push_back(rxdata);
            rx_cyc.push_back(cyc);
        end
        if (txundr) undr_cnt++;
        if (frameend) fend_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    function automatic logic [31:0] mask(input int dw);
        return (dw == 31) ? 32'hFFFF_FFFF : ((32'h1 << (dw + 1)) - 32'h1);
    endfunction

    function automatic int bit_idx(input int i, input int dw, input logic bo);
        return bo ? i : dw - i;
    endfunction

    // every word start (frame start plus each completed word) takes one held word or underruns
    function automatic int exp_undr(input int words_done, input int ntx);
        return (words_done + 1 > ntx) ? (words_done + 1 - ntx) : 0;
    endfunction

    function automatic logic [31:0] rx_at(input int i);
        if (i < rx_log.size()) return rx_log[i];
        return 'x;
    endfunction

    function automatic logic [31:0] miso_at(input int i);
        if (i < miso_words.size()) return miso_words[i];
        return 'x;
    endfunction

    task automatic do_reset();
        sclk = cpol; csb = 1'b1; mosi = 1'b0; txvalid = 1'b0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic load_tx(input logic [31:0] w);
        txdata = w; txvalid = 1'b1;
        tick(1);
        txvalid = 1'b0;
    endtask

    // Behavioural master: sends nbits over up to two words, records MISO per word.
    task automatic spi_frame(input logic [31:0] w0, input logic [31:0] w1, input int nbits,
                             input int hp);
        int dw;
        int sent;
        logic [31:0] cur, got;
        dw = int'(dwidth);
        sent = 0;
        csb = 1'b0;
        for (int wi = 0; wi < 2 && sent < nbits; wi++) begin
            cur = (wi == 0) ? w0 : w1;
            got = '0;
            for (int i = 0; i <= dw && sent < nbits; i++) begin
                if (!cpha) begin
                    mosi = cur[bit_idx(i, dw, border)];
                    tick(hp); sclk = ~sclk;
                    got[bit_idx(i, dw, border)] = miso;
                    last_sample_cyc = cyc;
                    tick(hp); sclk = ~sclk;
                end else begin
                    tick(hp); sclk = ~sclk;
                    mosi = cur[bit_idx(i, dw, border)];
                    tick(hp); sclk = ~sclk;
                    got[bit_idx(i, dw, border)] = miso;
                    last_sample_cyc = cyc;
                end
                sent++;
            end
            miso_words.push_back(got);
        end
        tick(hp);
        csb = 1'b1; mosi = 1'b0;
        tick(4 * hp + 8);
    endtask

    initial begin
        int r0, u0, f0, m0, t, feed_to;
        logic [31:0] wa, wb, wc, txq[3];

        rst = 1'b1; txdata = '0; cpol = 0; cpha = 0; border = 0; dwidth = 5'd7;

        // mode 0, 8-bit MSB first, preloaded 0xA5
        do_reset();
        check("reset_flags", {31'h0, txready}, 32'h1);
        check("reset_outs", {25'h0, txundr, rxvalid, frameact, frameend, miso, misooe, 1'b0}, 32'h0);
        check("reset_rxdata", rxdata, 32'h0);
        load_tx(32'hA5);
        check("t1_ready_low", {31'h0, txready}, 32'h0);
        r0 = rx_log.size(); u0 = undr_cnt; f0 = fend_cnt; m0 = miso_words.size();
        spi_frame(32'h3C, 32'h0, 8, 8);
        check("t1_miso", miso_at(m0), 32'hA5);
        check("t1_rx_cnt", rx_log.size() - r0, 1);
        check("t1_rxdata", rx_at(r0), 32'h3C);
        check("t1_latency", (r0 < rx_cyc.size()) ? rx_cyc[r0] - last_sample_cyc : -1, SS + 2);
        check("t1_frameend", fend_cnt - f0, 1);
        check("t1_undr", undr_cnt - u0, exp_undr(1, 1));
        check("t1_misooe", {31'h0, misooe}, 32'h0);

        // mode 3, 32-bit LSB first, two words fed on TXREADY
        cpol = 1; cpha = 1; border = 1; dwidth = 5'd31;
        do_reset();
        txq[0] = 32'h12345678; txq[1] = 32'hDEADBEEF; txq[2] = $urandom;
        wa = $urandom; wb = $urandom; feed_to = 0;
        r0 = rx_log.size(); u0 = undr_cnt; m0 = miso_words.size();
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    t = 0;
                    while (!txready && t < 3000) begin tick(1); t++; end
                    if (t >= 3000) feed_to++;
                    load_tx(txq[k]);
                end
            end
            begin
                tick(4);
                spi_frame(wa, wb, 64, 8);
            end
        join
        check("t2_feed_timeout", feed_to, 0);
        check("t2_miso0", miso_at(m0), 32'h12345678);
        check("t2_miso1", miso_at(m0 + 1), 32'hDEADBEEF);
        check("t2_rx_cnt", rx_log.size() - r0, 2);
        check("t2_rx0", rx_at(r0), wa);
        check("t2_rx1", rx_at(r0 + 1), wb);
        check("t2_undr", undr_cnt - u0, exp_undr(2, 3));

        // mode 1, nothing loaded: zeros out, underrun at start
        cpol = 0; cpha = 1; border = 0; dwidth = 5'd7;
        do_reset();
        r0 = rx_log.size(); u0 = undr_cnt; m0 = miso_words.size();
        spi_frame(32'h81, 32'h0, 8, 8);
        check("t3_miso", miso_at(m0), 32'h0);
        check("t3_rxdata", rx_at(r0), 32'h81);
        check("t3_rx_cnt", rx_log.size() - r0, 1);
        check("t3_undr", undr_cnt - u0, exp_undr(1, 0));

        // mode 2, 16-bit word aborted after 9 bits, then a full word
        cpol = 1; cpha = 0; border = $urandom_range(0, 1); dwidth = 5'd15;
        do_reset();
        r0 = rx_log.size(); f0 = fend_cnt;
        spi_frame($urandom, 32'h0, 9, 8);
        check("t4_no_rxvalid", rx_log.size() - r0, 0);
        check("t4_frameend", fend_cnt - f0, 1);
        check("t4_misooe", {31'h0, misooe}, 32'h0);
        wa = $urandom;
        spi_frame(wa, 32'h0, 16, 8);
        check("t4_rx_cnt", rx_log.size() - r0, 1);
        check("t4_rxdata", rx_at(r0), wa & mask(15));

        // TXVALID during the START cycle with the holding register empty
        cpol = 0; cpha = 0; border = 0; dwidth = 5'd7;
        do_reset();
        wc = $urandom; wa = $urandom; wb = $urandom; feed_to = 0;
        r0 = rx_log.size(); u0 = undr_cnt; m0 = miso_words.size();
        fork
            begin
                t = 0;
                while (!frameact && t < 200) begin @(negedge clk); t++; end
                if (t >= 200) feed_to++;
                txdata = wc; txvalid = 1'b1;
                @(posedge clk); #1;
                txvalid = 1'b0;
                tick(20);
                check("t5_ready_held", {31'h0, txready}, 32'h0);
            end
            spi_frame(wa, wb, 16, 8);
        join
        check("t5_frameact_seen", feed_to, 0);
        check("t5_miso0", miso_at(m0), 32'h0);
        check("t5_miso1", miso_at(m0 + 1), wc & mask(7));
        check("t5_undr", undr_cnt - u0, exp_undr(2, 1));
        check("t5_ready_after", {31'h0, txready}, 32'h1);
        check("t5_rx1", rx_at(r0 + 1), wb & mask(7));

        // reset in the middle of a frame
        do_reset();
        csb = 1'b0;
        for (int e = 0; e < 4; e++) begin tick(8); sclk = ~sclk; end
        tick(4);
        rst = 1'b1;
        tick(2);
        check("t6_rst_outs", {27'h0, txready, frameact, misooe, miso, rxvalid}, 32'h10);
        csb = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(6);
        r0 = rx_log.size();
        spi_frame(32'h5A, 32'h0, 8, 8);
        check("t6_rx_cnt", rx_log.size() - r0, 1);
        check("t6_rxdata", rx_at(r0), 32'h5A);

        // SCLK = SYSCLK/4 in every mode, random order and width
        for (int md = 0; md < 4; md++) begin
            cpol = md[1]; cpha = md[0];
            border = $urandom_range(0, 1);
            dwidth = 5'($urandom_range(0, 31));
            do_reset();
            wa = $urandom; wb = $urandom;
            r0 = rx_log.size();
            spi_frame(wa, wb, 2 * (int'(dwidth) + 1), 2);
            check("t7_rx_cnt", rx_log.size() - r0, 2);
            check("t7_rx0", rx_at(r0), wa & mask(int'(dwidth)));
            check("t7_rx1", rx_at(r0 + 1), wb & mask(int'(dwidth)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
